// File: rtl/instruction_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_pkg
//
// Shared definitions for the MIPS32 fetch stage: default reset PC, the NOP
// encoding presented to decode when nothing is buffered, the fetch FSM state
// encodings, the pc_source encodings used by the downstream redirect
// generator, and the layout of one fetch buffer entry.
// ---------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

    localparam logic [31:0] IF_RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] IF_NOP              = 32'h0000_0000;

    // Fetch FSM states
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } ifState_e;

    // Where the next PC comes from; produced by the redirect generator
    typedef enum logic [1:0] {
        PC_SRC_PLUS4  = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JUMP   = 2'd2,
        PC_SRC_JR     = 2'd3
    } pcSource_e;

    // One buffered instruction together with its PC and PC+4
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic [31:0] pcPlus4;
    } fetchEntry_t;

    localparam int FETCH_ENTRY_W = $bits(fetchEntry_t);

    function automatic logic isWordAligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
//
// DEPTH-entry synchronous FIFO holding fetched instruction entries.
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   push_i/data_i  write an entry (also allowed when full if pop_i is set)
//   pop_i          remove the head entry (ignored when empty)
//   flush_i        discard all entries; wins over push_i and pop_i
//   data_o         head entry (undefined when empty_o)
//   full_o/empty_o occupancy flags
//   count_o        number of valid entries
// ---------------------------------------------------------------------------
module fetch_buffer
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = FETCH_ENTRY_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W-1:0] wrPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rdPtr_q];

    // A push into a full buffer is only legal when the head leaves in the same cycle
    assign doPop  = pop_i && !empty_o && !flush_i;
    assign doPush = push_i && !flush_i && (!full_o || doPop);

    // Storage array; contents need no reset because count_q gates visibility
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; flush simply rewinds everything
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage of the MIPS32 core. Owns the PC, issues one word request at a
// time to instruction memory, buffers returned words in fetch_buffer and hands
// them to control_unit/decode over a valid/ready handshake. Downstream
// redirects flush the buffer and retarget the PC; the response to a request
// that was in flight at redirect time is discarded. A misaligned redirect
// target raises a sticky fetch_fault and halts fetch until rst.
//
// Optional feature (macro FETCH_PERF_CNT_EN): adds perf_stall_cycles and
// perf_flush_count saturating counters and their output ports.
//
// Parameters:
//   RESET_PC   PC loaded on reset (must be word-aligned)
//   BUF_DEPTH  fetch buffer entries, 2 or 4
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req_valid/addr/ready instruction memory request channel
//   imem_resp_valid/data      instruction memory response channel
//   redirect_valid/target     PC redirect from downstream
//   id_valid/instruction/pc/pc_plus4, id_ready   decode handshake
//   fetch_fault               sticky misaligned-redirect flag
//   perf_stall_cycles         (FETCH_PERF_CNT_EN) cycles without id_valid, not halted
//   perf_flush_count          (FETCH_PERF_CNT_EN) accepted redirects
// ---------------------------------------------------------------------------
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IF_RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        id_valid,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    input  logic        id_ready,
    output logic        fetch_fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH+1);

    ifState_e    state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] reqPc_q, reqPc_d;
    logic        outstanding_q, outstanding_d;
    logic        dropPending_q, dropPending_d;
    logic        fault_q, fault_d;

    logic [CNT_W-1:0] bufCount;
    logic             bufFull;
    logic             bufEmpty;
    logic             bufPush;
    logic             bufPop;
    logic             bufFlush;
    fetchEntry_t      pushEntry;
    fetchEntry_t      headEntry;
    logic [CNT_W:0]   inFlight;
    logic [CNT_W:0]   countAfter;
    logic             roomForReq;
    logic             reqAccept;
    logic             respTaken;
    logic             redirectTaken;
    logic             redirectAligned;

    // Handshake and event decode shared by the datapath and the FSM
    assign inFlight        = {1'b0, bufCount} + {{CNT_W{1'b0}}, outstanding_q};
    assign roomForReq      = (inFlight < (CNT_W+1)'(BUF_DEPTH));
    assign imem_req_valid  = (state_q == S_REQ) && roomForReq && !rst;
    assign imem_req_addr   = pc_q;
    assign reqAccept       = imem_req_valid && imem_req_ready;
    assign respTaken       = (state_q == S_WAIT) && outstanding_q && imem_resp_valid;
    // Redirects are ignored once halted; only rst leaves S_HALT
    assign redirectTaken   = redirect_valid && (state_q != S_HALT);
    assign redirectAligned = isWordAligned(redirect_target);

    assign bufFlush  = redirectTaken;
    assign bufPush   = respTaken && !dropPending_q && !redirectTaken;
    assign bufPop    = id_valid && id_ready && !redirectTaken;
    assign pushEntry = '{instruction: imem_resp_data, pc: reqPc_q, pcPlus4: reqPc_q + 32'd4};
    assign countAfter = {1'b0, bufCount} + {{CNT_W{1'b0}}, bufPush} - {{CNT_W{1'b0}}, bufPop};

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (FETCH_ENTRY_W)
    ) u_fetch_buffer (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bufPush),
        .data_i  (pushEntry),
        .pop_i   (bufPop),
        .flush_i (bufFlush),
        .data_o  (headEntry),
        .full_o  (bufFull),
        .empty_o (bufEmpty),
        .count_o (bufCount)
    );

    // Decode sees the head entry directly; an empty buffer shows a NOP at PC 0
    assign id_valid       = !bufEmpty;
    assign id_instruction = id_valid ? headEntry.instruction : IF_NOP;
    assign id_pc          = id_valid ? headEntry.pc          : 32'h0;
    assign id_pc_plus4    = id_valid ? headEntry.pcPlus4     : 32'h0;
    assign fetch_fault    = fault_q;

    // Next-state logic. A redirect overrides everything else; if a request
    // is still in flight afterwards we park in S_WAIT with dropPending set so
    // the stale word is swallowed before the first request to the new target.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        reqPc_d       = reqPc_q;
        outstanding_d = outstanding_q;
        dropPending_d = dropPending_q;
        fault_d       = fault_q;

        if (redirectTaken) begin
            if (redirectAligned) begin
                pc_d = redirect_target;
                if (reqAccept || (outstanding_q && !respTaken)) begin
                    outstanding_d = 1'b1;
                    dropPending_d = 1'b1;
                    state_d       = S_WAIT;
                end else begin
                    outstanding_d = 1'b0;
                    dropPending_d = 1'b0;
                    state_d       = S_REQ;
                end
            end else begin
                fault_d       = 1'b1;
                outstanding_d = 1'b0;
                dropPending_d = 1'b0;
                state_d       = S_HALT;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (reqAccept) begin
                        reqPc_d       = pc_q;
                        pc_d          = pc_q + 32'd4;
                        outstanding_d = 1'b1;
                        state_d       = S_WAIT;
                    end else if (bufFull) begin
                        state_d = S_HOLD;
                    end
                end
                S_WAIT: begin
                    if (respTaken) begin
                        outstanding_d = 1'b0;
                        dropPending_d = 1'b0;
                        state_d       = (countAfter >= (CNT_W+1)'(BUF_DEPTH)) ? S_HOLD : S_REQ;
                    end
                end
                S_HOLD: begin
                    if (roomForReq) begin
                        state_d = S_REQ;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_HALT;
                end
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            reqPc_q       <= RESET_PC;
            outstanding_q <= 1'b0;
            dropPending_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            reqPc_q       <= reqPc_d;
            outstanding_q <= outstanding_d;
            dropPending_q <= dropPending_d;
            fault_q       <= fault_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stallCnt_q;
    logic [31:0] flushCnt_q;

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt_q <= 32'h0;
            flushCnt_q <= 32'h0;
        end else begin
            if (!id_valid && (state_q != S_HALT) && (stallCnt_q != 32'hFFFF_FFFF)) begin
                stallCnt_q <= stallCnt_q + 32'd1;
            end
            if (redirectTaken && (flushCnt_q != 32'hFFFF_FFFF)) begin
                flushCnt_q <= flushCnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = stallCnt_q;
    assign perf_flush_count  = flushCnt_q;
`endif

endmodule
